line_window_ctrl: RTL and testbench

Raster sequencer for a chain of line shift RAMs feeding a KERNEL×KERNEL window operator in the DSP base-apply path.
- Pulls one pixel per clock from the upstream source and gates the line RAMs' `clken`.
- Primes and drains the line buffers around each frame, injecting zero lines at the bottom edge.
- Emits window-valid, window-centre coordinates and border flags aligned with the line-RAM outputs.

---
 rtl/line_win_pkg.sv | 22 ++
 rtl/raster_counter.sv | 57 +++++
 rtl/line_window_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_line_window_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/line_win_pkg.sv
// Shared types and elaboration helpers for the line-window sequencer.
package line_win_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StRun,
    StFlush,
    StDone
  } state_t;

  // Rows/columns the window extends on each side of its centre.
  function automatic int unsigned half_of(input int unsigned kernel);
    return kernel / 2;
  endfunction

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Column/row raster counter: column wraps at Cols-1, row advances on each
// column wrap and wraps to 0 after the row given by row_last.
module raster_counter
  import line_win_pkg::*;
#(
  parameter int unsigned Cols = 640,
  parameter int unsigned ColW = cnt_width(Cols),
  parameter int unsigned RowW = 9
) (
  input  logic            clock,
  input  logic            clr_n,
  input  logic            en,
  input  logic            clr,
  input  logic [RowW-1:0] row_last,
  output logic [ColW-1:0] col,
  output logic [RowW-1:0] row,
  output logic            col_wrap,
  output logic            last
);

  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;

  assign col_wrap = (col_q == ColW'(Cols - 1));
  assign last     = col_wrap && (row_q == row_last);
  assign col      = col_q;
  assign row      = row_q;

  // Next count: clear wins over enable; column wrap carries into the row.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr) begin
      col_d = '0;
      row_d = '0;
    end else if (en) begin
      if (col_wrap) begin
        col_d = '0;
        row_d = last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Count registers.
  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/line_window_ctrl.sv
// Raster sequencer for a line shift-RAM chain feeding a KERNEL x KERNEL
// window: primes the lines, streams one pixel per clock, then drains with
// zero lines so the bottom edge gets padding.
module line_window_ctrl
  import line_win_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned KERNEL     = 3
) (
  input  logic                             clock,
  input  logic                             clr_n,
  input  logic                             frame_start,
  input  logic                             pix_valid,
  output logic                             pix_ready,
  output logic                             ram_clken,
  output logic                             win_valid,
  output logic [cnt_width(IMG_WIDTH)-1:0]  win_col,
  output logic [cnt_width(IMG_HEIGHT)-1:0] win_row,
  output logic [3:0]                       border,
  output logic                             frame_done,
  output logic                             underflow,
  output logic                             restart_err
);

  localparam int unsigned Half   = half_of(KERNEL);
  localparam int unsigned ColW   = cnt_width(IMG_WIDTH);
  localparam int unsigned RowW   = cnt_width(IMG_HEIGHT);
  // Ingest row runs past the image by Half lines while draining.
  localparam int unsigned InRowW = cnt_width(IMG_HEIGHT + Half);
  localparam logic [InRowW-1:0] InRowLast = InRowW'(IMG_HEIGHT + Half - 1);

  state_t state_q, state_d;

  logic              accept, busy, live, ph_clr;
  logic [ColW-1:0]   in_col, ph_col;
  logic [InRowW-1:0] in_row, centre_row;
  logic [RowW-1:0]   ph_row, ph_row_last;
  logic              in_col_wrap, in_last, ph_col_wrap, ph_last;

  logic              win_valid_q, frame_done_q, underflow_q, underflow_d;
  logic              restart_q, restart_d;
  logic [ColW-1:0]   win_col_q;
  logic [RowW-1:0]   win_row_q;

  // Ingest raster position of the pixel entering the line chain.
  raster_counter #(
    .Cols (IMG_WIDTH),
    .ColW (ColW),
    .RowW (InRowW)
  ) u_ingest (
    .clock    (clock),
    .clr_n    (clr_n),
    .en       (busy),
    .clr      (accept),
    .row_last (InRowLast),
    .col      (in_col),
    .row      (in_row),
    .col_wrap (in_col_wrap),
    .last     (in_last)
  );

  // Length of the current FILL/RUN/FLUSH phase, restarted on each transition.
  raster_counter #(
    .Cols (IMG_WIDTH),
    .ColW (ColW),
    .RowW (RowW)
  ) u_phase (
    .clock    (clock),
    .clr_n    (clr_n),
    .en       (busy),
    .clr      (ph_clr),
    .row_last (ph_row_last),
    .col      (ph_col),
    .row      (ph_row),
    .col_wrap (ph_col_wrap),
    .last     (ph_last)
  );

  // Last line index of the phase currently being counted.
  always_comb begin
    ph_row_last = '0;
    unique case (state_q)
      StFill:  ph_row_last = RowW'(Half - 1);
      StRun:   ph_row_last = RowW'(IMG_HEIGHT - Half - 1);
      StFlush: ph_row_last = RowW'(Half - 1);
      default: ph_row_last = '0;
    endcase
  end

  // Phase sequencing; frame_start is only honoured in idle.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    ph_clr  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          state_d = StFill;
          accept  = 1'b1;
          ph_clr  = 1'b1;
        end
      end
      StFill: begin
        if (ph_last) begin
          state_d = StRun;
          ph_clr  = 1'b1;
        end
      end
      StRun: begin
        if (ph_last) begin
          state_d = StFlush;
          ph_clr  = 1'b1;
        end
      end
      StFlush: begin
        if (ph_last) begin
          state_d = StDone;
          ph_clr  = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Per-state strobes; in FLUSH the RAMs are not clocked so zeros shift in.
  always_comb begin
    pix_ready = (state_q == StFill) || (state_q == StRun);
    ram_clken = pix_ready && pix_valid;
    busy      = pix_ready || (state_q == StFlush);
    live      = (state_q == StRun) || (state_q == StFlush);
  end

  // Sticky error flags; an accepted frame_start clears both.
  always_comb begin
    underflow_d = underflow_q;
    restart_d   = restart_q;
    if (accept) begin
      underflow_d = 1'b0;
      restart_d   = 1'b0;
    end else begin
      if (pix_ready && !pix_valid) underflow_d = 1'b1;
      if (frame_start && (state_q != StIdle)) restart_d = 1'b1;
    end
  end

  // Centre sits Half lines behind the line being written.
  assign centre_row = in_row - InRowW'(Half);

  // State and outputs; coordinates delayed one cycle to match the RAM read.
  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      state_q      <= StIdle;
      win_valid_q  <= 1'b0;
      win_col_q    <= '0;
      win_row_q    <= '0;
      frame_done_q <= 1'b0;
      underflow_q  <= 1'b0;
      restart_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_valid_q  <= live;
      win_col_q    <= live ? in_col : '0;
      win_row_q    <= live ? centre_row[RowW-1:0] : '0;
      frame_done_q <= (state_q == StDone);
      underflow_q  <= underflow_d;
      restart_q    <= restart_d;
    end
  end

  // Edge proximity flags {top, bottom, left, right}, only while a window is live.
  always_comb begin
    border = '0;
    if (win_valid_q) begin
      border[3] = win_row_q < RowW'(Half);
      border[2] = win_row_q > RowW'(IMG_HEIGHT - 1 - Half);
      border[1] = win_col_q < ColW'(Half);
      border[0] = win_col_q > ColW'(IMG_WIDTH - 1 - Half);
    end
  end

  assign win_valid   = win_valid_q;
  assign win_col     = win_col_q;
  assign win_row     = win_row_q;
  assign frame_done  = frame_done_q;
  assign underflow   = underflow_q;
  assign restart_err = restart_q;

  // Counter outputs not needed for sequencing.
  logic unused_sig;
  assign unused_sig = ^{ph_col, ph_row, ph_col_wrap, in_col_wrap, in_last, centre_row};

endmodule

// File: tb/tb_line_window_ctrl.sv
// Directed bench: 8x6 image with a 3x3 kernel, plus a 5x5 instance sharing
// the same stimulus.
module tb_line_window_ctrl;

  localparam int W = 8;
  localparam int H = 6;

  logic       clock = 1'b0;
  logic       clr_n, frame_start, pix_valid;
  logic       pix_ready, ram_clken, win_valid, frame_done, underflow, restart_err;
  logic [2:0] win_col, win_row;
  logic [3:0] border;
  logic       pix_ready_5, ram_clken_5, win_valid_5, frame_done_5, underflow_5, restart_err_5;
  logic [2:0] win_col_5, win_row_5;
  logic [3:0] border_5;

  int n_vec = 0;
  int n_miss = 0;

  // Per-frame observations
  int   r_first_ready, r_n_ready, r_first_valid, r_n_valid, r_done_at, r_n_done;
  int   r_coord_bad, r_flush_clken, r_bottom;
  int   r5_first_ready, r5_first_valid, r5_n_valid, r5_done_at, r5_bad, r5_top, r5_left;
  logic r_clken_drop, r_uf_before, r_uf_after, r_rerr_before, r_uf_at1, r_rerr_at1;
  logic r_uf_end, r_rerr_end;

  line_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL(3)) dut (
    .clock       (clock),
    .clr_n       (clr_n),
    .frame_start (frame_start),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .ram_clken   (ram_clken),
    .win_valid   (win_valid),
    .win_col     (win_col),
    .win_row     (win_row),
    .border      (border),
    .frame_done  (frame_done),
    .underflow   (underflow),
    .restart_err (restart_err)
  );

  line_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL(5)) dut5 (
    .clock       (clock),
    .clr_n       (clr_n),
    .frame_start (frame_start),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready_5),
    .ram_clken   (ram_clken_5),
    .win_valid   (win_valid_5),
    .win_col     (win_col_5),
    .win_row     (win_row_5),
    .border      (border_5),
    .frame_done  (frame_done_5),
    .underflow   (underflow_5),
    .restart_err (restart_err_5)
  );

  always #5 clock = ~clock;

`define CHK(tag, obs, exp) \
  n_vec++; \
  assert (32'(obs) === 32'(exp)) else begin \
    n_miss++; \
    $error("FAIL %s: observed %0d expected %0d", tag, 32'(obs), 32'(exp)); \
  end

  function automatic logic [3:0] exp_border(input int row, input int col, input int half);
    return {row < half, row > H - 1 - half, col < half, col > W - 1 - half};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One frame: pulse frame_start, then observe 75 cycles (k = cycles after the pulse).
  task automatic run_frame(input int drop_at, input int restart_at);
    int v, v5;
    v = 0; v5 = 0;
    r_first_ready = -1; r_n_ready = 0; r_first_valid = -1; r_done_at = -1; r_n_done = 0;
    r_coord_bad = 0; r_flush_clken = 0; r_bottom = 0;
    r5_first_ready = -1; r5_first_valid = -1; r5_done_at = -1; r5_bad = 0; r5_top = 0;
    r5_left = 0;
    r_clken_drop = 1'bx; r_uf_before = 1'bx; r_uf_after = 1'bx; r_rerr_before = 1'bx;
    r_uf_at1 = 1'bx; r_rerr_at1 = 1'bx;
    frame_start = 1'b1;
    pix_valid   = 1'b1;
    step();
    frame_start = 1'b0;
    for (int k = 1; k <= 75; k++) begin
      pix_valid   = (k == drop_at) ? 1'b0 : 1'b1;
      frame_start = (k == restart_at);
      #1;
      if (pix_ready) begin
        if (r_first_ready < 0) r_first_ready = k;
        r_n_ready++;
      end
      if (win_valid) begin
        if (r_first_valid < 0) r_first_valid = k;
        if (32'(win_row) !== v / W || 32'(win_col) !== v % W ||
            border !== exp_border(v / W, v % W, 1)) r_coord_bad++;
        if (win_row == 3'd5 && border[2]) r_bottom++;
        v++;
      end
      if (frame_done) begin
        r_done_at = k;
        r_n_done++;
      end
      if (k >= 49 && k <= 56 && ram_clken !== 1'b0) r_flush_clken++;
      if (k == drop_at) begin
        r_clken_drop = ram_clken;
        r_uf_before  = underflow;
      end
      if (k == drop_at + 1) r_uf_after = underflow;
      if (k == restart_at) r_rerr_before = restart_err;
      if (k == 1) begin
        r_uf_at1   = underflow;
        r_rerr_at1 = restart_err;
      end
      if (pix_ready_5 && r5_first_ready < 0) r5_first_ready = k;
      if (win_valid_5) begin
        if (r5_first_valid < 0) r5_first_valid = k;
        if (32'(win_row_5) !== v5 / W || 32'(win_col_5) !== v5 % W ||
            border_5 !== exp_border(v5 / W, v5 % W, 2)) r5_bad++;
        if (border_5[3]) r5_top++;
        if (border_5[1]) r5_left++;
        v5++;
      end
      if (frame_done_5) r5_done_at = k;
      step();
    end
    frame_start = 1'b0;
    pix_valid   = 1'b1;
    r_n_valid   = v;
    r5_n_valid  = v5;
    r_uf_end    = underflow;
    r_rerr_end  = restart_err;
  endtask

  initial begin
    clr_n       = 1'b0;
    frame_start = 1'b0;
    pix_valid   = 1'b1;
    #2;
    `CHK("rst_pix_ready", pix_ready, 0);
    `CHK("rst_ram_clken", ram_clken, 0);
    `CHK("rst_win_valid", win_valid, 0);
    `CHK("rst_win_col", win_col, 0);
    `CHK("rst_win_row", win_row, 0);
    `CHK("rst_border", border, 0);
    `CHK("rst_frame_done", frame_done, 0);
    `CHK("rst_underflow", underflow, 0);
    `CHK("rst_restart_err", restart_err, 0);
    #10 clr_n = 1'b1;
    step();
    repeat (2) step();
    `CHK("idle_pix_ready", pix_ready, 0);

    // Nominal frame
    run_frame(-10, -10);
    `CHK("nom_first_ready", r_first_ready, 1);
    `CHK("nom_n_ready", r_n_ready, 48);
    `CHK("nom_first_valid", r_first_valid, 10);
    `CHK("nom_n_valid", r_n_valid, 48);
    `CHK("nom_done_at", r_done_at, 58);
    `CHK("nom_n_done", r_n_done, 1);
    `CHK("nom_coord_border_bad", r_coord_bad, 0);
    `CHK("flush_clken_cycles", r_flush_clken, 0);
    `CHK("bottom_row5_border", r_bottom, 8);
    `CHK("nom_underflow", r_uf_end, 0);
    `CHK("k5_fill_plus_one", r5_first_valid - r5_first_ready, 17);
    `CHK("k5_n_valid", r5_n_valid, 48);
    `CHK("k5_coord_border_bad", r5_bad, 0);
    `CHK("k5_top_count", r5_top, 16);
    `CHK("k5_left_count", r5_left, 12);
    `CHK("k5_done_at", r5_done_at, 66);

    // Underflow at row 2, col 3 (pixel 19, cycle 20)
    run_frame(20, -10);
    `CHK("uf_clken_at_drop", r_clken_drop, 0);
    `CHK("uf_before", r_uf_before, 0);
    `CHK("uf_after", r_uf_after, 1);
    `CHK("uf_sticky_end", r_uf_end, 1);
    `CHK("uf_done_at", r_done_at, 58);
    `CHK("uf_n_ready", r_n_ready, 48);

    // Restart pulse during RUN
    run_frame(-10, 30);
    `CHK("accept_clears_uf", r_uf_at1, 0);
    `CHK("rerr_before", r_rerr_before, 0);
    `CHK("rerr_sticky_end", r_rerr_end, 1);
    `CHK("rs_done_at", r_done_at, 58);
    `CHK("rs_n_valid", r_n_valid, 48);
    `CHK("rs_coord_border_bad", r_coord_bad, 0);

    // Next accepted frame clears restart_err; reset during FLUSH
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    `CHK("accept_clears_rerr", restart_err, 0);
    repeat (51) step();
    `CHK("pre_reset_win_valid", win_valid, 1);
    `CHK("pre_reset_win_row", win_row, 5);
    clr_n = 1'b0;
    #1;
    `CHK("mid_rst_pix_ready", pix_ready, 0);
    `CHK("mid_rst_ram_clken", ram_clken, 0);
    `CHK("mid_rst_win_valid", win_valid, 0);
    `CHK("mid_rst_win_col", win_col, 0);
    `CHK("mid_rst_win_row", win_row, 0);
    `CHK("mid_rst_border", border, 0);
    `CHK("mid_rst_frame_done", frame_done, 0);
    `CHK("mid_rst_k5_win_valid", win_valid_5, 0);
    #2 clr_n = 1'b1;
    repeat (4) step();
    `CHK("post_rst_idle", pix_ready, 0);
    run_frame(-10, -10);
    `CHK("post_rst_first_valid", r_first_valid, 10);
    `CHK("post_rst_n_valid", r_n_valid, 48);
    `CHK("post_rst_done_at", r_done_at, 58);
    `CHK("post_rst_coord_bad", r_coord_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
